midi_tx_encoder: RTL and testbench

//   Encodes note events (note number, velocity, on/off) into 3-byte MIDI channel messages.

---
 rtl/midi_tx_encoder.sv | 125 ++++++++++++
 tb/tb_midi_tx_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx_encoder.sv
// Note-event to MIDI channel-message encoder with an 8N1 serial output.
// Running status optionally suppresses a status byte identical to the previous one sent.
module midi_tx_encoder #(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 31250,
  parameter int CHANNEL        = 0,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_vel,
  output logic       midi_tx,
  output logic       byte_strobe,
  output logic       busy
);

  localparam int             DIV      = CLK_HZ / BAUD;
  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
  localparam logic [3:0]     CH       = 4'(CHANNEL);
  localparam logic [3:0]     STOP_IDX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START_MSG,
    SEND_STATUS,
    SEND_D1,
    SEND_D2
  } state_t;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note;
    logic [6:0] vel;
  } ev_t;

  state_t        state_q, state_d;
  ev_t           ev_q;
  logic [7:0]    last_status_q;
  logic [CW-1:0] baud_cnt_q;
  logic [3:0]    bit_idx_q;
  logic          ready_q, busy_q;

  logic       accept, sending, baud_wrap, byte_done, tx_bit;
  logic [7:0] status, cur_byte;
  logic [3:0] data_idx;

  assign accept    = ev_valid && ready_q;
  assign status    = {1'b1, 2'b00, ev_q.note_on, CH};
  assign sending   = (state_q == SEND_STATUS) || (state_q == SEND_D1) || (state_q == SEND_D2);
  assign baud_wrap = (baud_cnt_q == DIV_LAST);
  assign byte_done = sending && baud_wrap && (bit_idx_q == STOP_IDX);
  assign data_idx  = bit_idx_q - 4'd1;

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      SEND_STATUS: cur_byte = status;
      SEND_D1:     cur_byte = {1'b0, ev_q.note};
      SEND_D2:     cur_byte = {1'b0, ev_q.vel};
      default:     cur_byte = 8'h00;
    endcase
  end

  // Frame: index 0 start, 1..8 data LSB first, 9 stop.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_idx_q == 4'd0)          tx_bit = 1'b0;
    else if (bit_idx_q == STOP_IDX) tx_bit = 1'b1;
    else                            tx_bit = cur_byte[data_idx[2:0]];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = START_MSG;
      START_MSG:   state_d = ((RUNNING_STATUS == 0) || (status != last_status_q)) ? SEND_STATUS
                                                                                   : SEND_D1;
      SEND_STATUS: if (byte_done) state_d = SEND_D1;
      SEND_D1:     if (byte_done) state_d = SEND_D2;
      SEND_D2:     if (byte_done) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ev_q          <= '0;
      last_status_q <= 8'h00;
      baud_cnt_q    <= '0;
      bit_idx_q     <= 4'd0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered so ready comes up one edge after reset and drops the cycle after a transfer.
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      if (accept) ev_q <= '{note_on: ev_note_on, note: ev_note, vel: ev_vel};
      if (byte_done && (state_q == SEND_STATUS)) last_status_q <= status;
      if (sending) begin
        if (baud_wrap) begin
          baud_cnt_q <= '0;
          bit_idx_q  <= (bit_idx_q == STOP_IDX) ? 4'd0 : bit_idx_q + 4'd1;
        end else begin
          baud_cnt_q <= baud_cnt_q + 1'b1;
        end
      end else begin
        baud_cnt_q <= '0;
        bit_idx_q  <= 4'd0;
      end
    end
  end

  assign ev_ready    = ready_q;
  assign busy        = busy_q;
  assign byte_strobe = byte_done;
  assign midi_tx     = sending ? tx_bit : 1'b1;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Bench for midi_tx_encoder: two instances (ch0 running status, ch5 always-status) share stimulus;
// a serial decoder recovers bytes which are compared to a table and to a message-level model.
module tb_midi_tx_encoder;

  localparam int CLK_HZ   = 8000;
  localparam int BAUD     = 1000;
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int BYTE_CYC = 10 * DIV;
  localparam int TMO      = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_note_on = 1'b0;
  logic [6:0] ev_note = 7'd0;
  logic [6:0] ev_vel = 7'd0;
  logic       rdy[2], tx[2], stb[2], bsy[2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  midi_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .RUNNING_STATUS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(rdy[0]), .ev_note_on(ev_note_on),
    .ev_note(ev_note), .ev_vel(ev_vel), .midi_tx(tx[0]), .byte_strobe(stb[0]), .busy(bsy[0]));

  midi_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(5), .RUNNING_STATUS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(rdy[1]), .ev_note_on(ev_note_on),
    .ev_note(ev_note), .ev_vel(ev_vel), .midi_tx(tx[1]), .byte_strobe(stb[1]), .busy(bsy[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: channel of each instance and whether it repeats status bytes.
  int         ch_of[2] = '{0, 5};
  bit         always_status[2] = '{1'b0, 1'b1};
  logic [7:0] m_last[2];
  logic [7:0] exp_q[2][$];

  task automatic model(input int i, input logic on, input logic [6:0] note, input logic [6:0] vel);
    logic [7:0] st;
    st = 8'(8'h80 + (on ? 16 : 0) + ch_of[i]);
    if (always_status[i] || st != m_last[i]) begin
      exp_q[i].push_back(st);
      m_last[i] = st;
    end
    exp_q[i].push_back({1'b0, note});
    exp_q[i].push_back({1'b0, vel});
  endtask

  // Serial decoder: samples mid-bit, checks framing and strobe position.
  logic [7:0] got_q[2][$];
  int         start_q[2][$];
  int         stbc_q[2][$];
  int         stb_cnt[2] = '{0, 0};
  bit         rx_act[2] = '{1'b0, 1'b0};
  int         rx_cnt[2];
  logic [9:0] rx_sh[2];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rx_act[i] = 1'b0;
      end else begin
        if (stb[i]) begin
          stb_cnt[i]++;
          stbc_q[i].push_back(cyc);
        end
        if (!rx_act[i] && tx[i] == 1'b0) begin
          rx_act[i] = 1'b1;
          rx_cnt[i] = 0;
          start_q[i].push_back(cyc);
        end
        if (rx_act[i]) begin
          if (rx_cnt[i] % DIV == DIV / 2) rx_sh[i][4'(rx_cnt[i] / DIV)] = tx[i];
          if (rx_cnt[i] == BYTE_CYC - 1) begin
            check("strobe_at_stop_end", 32'(stb[i]), 32'd1);
            check("frame_start_stop", 32'({rx_sh[i][9], rx_sh[i][0]}), 32'b10);
            got_q[i].push_back(rx_sh[i][8:1]);
            rx_act[i] = 1'b0;
          end else begin
            rx_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic clear_q();
    for (int i = 0; i < 2; i++) begin
      got_q[i].delete();
      exp_q[i].delete();
      start_q[i].delete();
      stbc_q[i].delete();
    end
  endtask

  task automatic cmp_model(input int i);
    check("model_nbytes", 32'(got_q[i].size()), 32'(exp_q[i].size()));
    for (int k = 0; k < exp_q[i].size() && k < got_q[i].size(); k++)
      check("model_byte", 32'(got_q[i][k]), 32'(exp_q[i][k]));
  endtask

  task automatic cmp_const(input string nm, input int i, input int n, input logic [47:0] b);
    logic [47:0] bb;
    bb = b;
    check(nm, 32'(got_q[i].size()), 32'(n));
    for (int k = 0; k < n && k < got_q[i].size(); k++)
      check(nm, 32'(got_q[i][k]), 32'(bb[47-8*k -: 8]));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("wait_ready_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bsy[0] || bsy[1] || !rdy[0] || !rdy[1]) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("wait_idle_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_tx_high", 32'(tx[i]), 32'd1);
      check("rst_ready_low", 32'(rdy[i]), 32'd0);
      check("rst_busy_low", 32'(bsy[i]), 32'd0);
      check("rst_strobe_low", 32'(stb[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    clear_q();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 8'h00;
      stb_cnt[i] = 0;
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check("ready_before_edge", 32'(rdy[i]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("ready_after_edge", 32'(rdy[i]), 32'd1);
      check("idle_tx", 32'(tx[i]), 32'd1);
    end
  endtask

  task automatic send_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int  bc[2];
    int  s0[2];
    bit  seen[2];
    int  n;
    wait_ready();
    clear_q();
    for (int i = 0; i < 2; i++) begin
      model(i, on, note, vel);
      s0[i] = stb_cnt[i];
      seen[i] = 1'b0;
      bc[i] = 1;
    end
    ev_valid = 1'b1;
    ev_note_on = on;
    ev_note = note;
    ev_vel = vel;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("start_msg_tx_high", 32'(tx[i]), 32'd1);
      check("ready_drop", 32'(rdy[i]), 32'd0);
      check("busy_rise", 32'(bsy[i]), 32'd1);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("start_bit_low", 32'(tx[i]), 32'd0);
    n = 0;
    while (!(seen[0] && seen[1]) && n < TMO) begin
      for (int i = 0; i < 2; i++) begin
        if (!seen[i]) begin
          if (bsy[i]) bc[i]++;
          else begin
            seen[i] = 1'b1;
            check("ready_with_busy_fall", 32'(rdy[i]), 32'd1);
          end
        end
      end
      if (!(seen[0] && seen[1])) @(negedge clk);
      n++;
    end
    if (n >= TMO) check("busy_timeout", 32'(n), 32'(0));
    for (int i = 0; i < 2; i++) begin
      check("busy_cycles", 32'(bc[i]), 32'(1 + exp_q[i].size() * BYTE_CYC));
      check("strobe_count", 32'(stb_cnt[i] - s0[i]), 32'(exp_q[i].size()));
      cmp_model(i);
    end
  endtask

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    int         n0;
    logic [23:0] b0;
    int         n1;
    logic [23:0] b1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    tbl[0] = '{1'b1, 7'd60,  7'd100, 3, 24'h903C64, 3, 24'h953C64};
    tbl[1] = '{1'b1, 7'd64,  7'd80,  2, 24'h405000, 3, 24'h954050};
    tbl[2] = '{1'b0, 7'd60,  7'd64,  3, 24'h803C40, 3, 24'h853C40};
    tbl[3] = '{1'b0, 7'd62,  7'd0,   2, 24'h3E0000, 3, 24'h853E00};
    tbl[4] = '{1'b1, 7'd127, 7'd0,   3, 24'h907F00, 3, 24'h957F00};

    #12;
    do_reset();

    for (int v = 0; v < 5; v++) begin
      send_event(tbl[v].on, tbl[v].note, tbl[v].vel);
      cmp_const("tbl_u0", 0, tbl[v].n0, {tbl[v].b0, 24'h0});
      cmp_const("tbl_u1", 1, tbl[v].n1, {tbl[v].b1, 24'h0});
    end

    // Reset in the middle of a data bit of the second byte.
    wait_ready();
    clear_q();
    ev_valid = 1'b1; ev_note_on = 1'b0; ev_note = 7'd10; ev_vel = 7'd20;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (1 + BYTE_CYC + 3 * DIV + 3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("abort_one_byte_done", 32'(got_q[i].size()), 32'd1);
      check("abort_busy", 32'(bsy[i]), 32'd1);
    end
    #2;
    do_reset();
    send_event(1'b1, 7'd64, 7'd80);
    cmp_const("post_reset_u0", 0, 3, {24'h904050, 24'h0});
    cmp_const("post_reset_u1", 1, 3, {24'h954050, 24'h0});

    // ev_valid held with changing values while busy.
    wait_ready();
    clear_q();
    for (int i = 0; i < 2; i++) model(i, 1'b1, 7'd10, 7'd20);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd10; ev_vel = 7'd20;
    @(posedge clk);
    @(negedge clk);
    ev_note_on = 1'b0; ev_note = 7'd99; ev_vel = 7'd99;
    bad = 0;
    repeat (15 * DIV) begin
      if (rdy[0] || rdy[1]) bad++;
      @(negedge clk);
    end
    check("held_ready_low", 32'(bad), 32'd0);
    ev_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 2; i++) cmp_model(i);
    cmp_const("held_u0", 0, 2, {16'h0A14, 32'h0});

    // Back-to-back messages with ev_valid held high.
    wait_ready();
    clear_q();
    for (int i = 0; i < 2; i++) stb_cnt[i] = 0;
    ev_valid = 1'b1; ev_note_on = 1'b0; ev_note = 7'd60; ev_vel = 7'd64;
    @(posedge clk);
    @(negedge clk);
    ev_note_on = 1'b1; ev_vel = 7'd100;
    n = 0;
    while (!rdy[0] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("b2b_timeout", 32'(n), 32'(0));
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    wait_idle();
    cmp_const("b2b_u0", 0, 6, 48'h803C40903C64);
    cmp_const("b2b_u1", 1, 6, 48'h853C40953C64);
    for (int i = 0; i < 2; i++) begin
      check("b2b_strobes", 32'(stb_cnt[i]), 32'd6);
      check("b2b_starts", 32'(start_q[i].size()), 32'd6);
      if (start_q[i].size() == 6 && stbc_q[i].size() == 6) begin
        check("b2b_intra_gap", 32'(start_q[i][1] - stbc_q[i][0]), 32'd1);
        check("b2b_msg_gap", 32'(start_q[i][3] - stbc_q[i][2]), 32'd3);
      end
    end

    // Random events against the model.
    for (int r = 0; r < 20; r++)
      send_event(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
